// File: rtl/div_seq_pkg.sv
// Shared encodings for the RV32M divide sequencer: divide op codes, FSM states
// and the subset of shared-ALU op codes the sequencer drives.
package div_seq_pkg;

  localparam int DIV_XLEN  = 32;
  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    DIV_ST_IDLE  = 3'd0,
    DIV_ST_ABS_A = 3'd1,
    DIV_ST_ABS_B = 3'd2,
    DIV_ST_ITER  = 3'd3,
    DIV_ST_FIX   = 3'd4,
    DIV_ST_DONE  = 3'd5
  } div_state_e;

  // Op codes of the shared EX-stage ALU.
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;

  // DIV and REM treat their operands as two's complement.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // REM/REMU return the remainder, DIV/DIVU the quotient.
  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_seq.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer. It owns no subtractor; every
// subtraction is borrowed from the shared EX-stage ALU, one restoring step per cycle.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int ITERS = DIV_ITERS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            abort_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            alu_sel_o,
  output logic [3:0]      alu_op_o,
  output logic [XLEN-1:0] alu_data1_o,
  output logic [XLEN-1:0] alu_data2_o,
  input  logic [XLEN-1:0] alu_res_i
);

  localparam int CNT_W = $clog2(ITERS);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e state, state_nxt;

  logic [1:0]      op_q;
  logic            sign_a_q;
  logic            sign_b_q;
  logic [XLEN-1:0] dividend_q;
  logic [XLEN-1:0] divisor_q;
  logic [XLEN-1:0] a_q;       // |dividend|, shifted out MSB-first; collects quotient bits
  logic [XLEN-1:0] b_q;       // |divisor|
  logic [XLEN-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] result_q;

  logic            accept;
  logic            div_zero;
  logic            overflow;
  logic            special;
  logic [XLEN-1:0] special_res;

  logic [XLEN:0]   shifted;
  logic            qbit;
  logic            last_iter;

  logic [XLEN-1:0] fix_val;
  logic            fix_neg;

  // Request decode: divide-by-zero and INT_MIN/-1 resolve without iterating.
  assign accept      = (state == DIV_ST_IDLE) && start_i && !abort_i;
  assign div_zero    = (divisor_i == '0);
  assign overflow    = op_is_signed(op_i) && (dividend_i == INT_MIN) && (divisor_i == '1);
  assign special     = div_zero || overflow;
  assign special_res = div_zero ? (op_is_rem(op_i) ? dividend_i : '1)
                                : (op_is_rem(op_i) ? '0 : dividend_i);

  assign shifted   = {rem_q, a_q[XLEN-1]};
  assign qbit      = shifted[XLEN] | (shifted[XLEN-1:0] >= b_q);
  assign last_iter = (cnt_q == CNT_W'(ITERS - 1));

  assign fix_val = op_is_rem(op_q) ? rem_q : a_q;
  assign fix_neg = op_is_rem(op_q) ? sign_a_q : (sign_a_q ^ sign_b_q);

  assign result_o = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DIV_ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    busy_o      = 1'b1;
    valid_o     = 1'b0;
    alu_sel_o   = 1'b0;
    alu_op_o    = ALU_ADD;
    alu_data1_o = '0;
    alu_data2_o = '0;
    case (state)
      DIV_ST_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          state_nxt = special ? DIV_ST_DONE : DIV_ST_ABS_A;
        end
      end
      DIV_ST_ABS_A: begin
        alu_sel_o   = 1'b1;
        alu_op_o    = ALU_SUB;
        alu_data2_o = dividend_q;
        state_nxt   = DIV_ST_ABS_B;
      end
      DIV_ST_ABS_B: begin
        alu_sel_o   = 1'b1;
        alu_op_o    = ALU_SUB;
        alu_data2_o = divisor_q;
        state_nxt   = DIV_ST_ITER;
      end
      DIV_ST_ITER: begin
        alu_sel_o   = 1'b1;
        alu_op_o    = ALU_SUB;
        alu_data1_o = shifted[XLEN-1:0];
        alu_data2_o = b_q;
        if (last_iter) begin
          state_nxt = DIV_ST_FIX;
        end
      end
      DIV_ST_FIX: begin
        alu_sel_o   = 1'b1;
        alu_op_o    = ALU_SUB;
        alu_data2_o = fix_val;
        state_nxt   = DIV_ST_DONE;
      end
      DIV_ST_DONE: begin
        valid_o   = !abort_i;
        state_nxt = DIV_ST_IDLE;
      end
      default: begin
        busy_o    = 1'b0;
        state_nxt = DIV_ST_IDLE;
      end
    endcase
    // A flush beats everything, including a same-cycle start request.
    if (abort_i) begin
      state_nxt = DIV_ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
    end else begin
      case (state)
        DIV_ST_IDLE: begin
          if (accept) begin
            op_q       <= op_i;
            sign_a_q   <= op_is_signed(op_i) & dividend_i[XLEN-1];
            sign_b_q   <= op_is_signed(op_i) & divisor_i[XLEN-1];
            dividend_q <= dividend_i;
            divisor_q  <= divisor_i;
            rem_q      <= '0;
            cnt_q      <= '0;
            if (special) begin
              result_q <= special_res;
            end
          end
        end
        DIV_ST_ABS_A: a_q <= sign_a_q ? alu_res_i : dividend_q;
        DIV_ST_ABS_B: b_q <= sign_b_q ? alu_res_i : divisor_q;
        DIV_ST_ITER: begin
          rem_q <= qbit ? alu_res_i : shifted[XLEN-1:0];
          a_q   <= {a_q[XLEN-2:0], qbit};
          cnt_q <= cnt_q + CNT_W'(1);
        end
        DIV_ST_FIX: result_q <= fix_neg ? alu_res_i : fix_val;
        default: ;
      endcase
    end
  end

endmodule
